// File: rtl/rsa_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// rsa_mem_arb_pkg
// Shared types and constants for the unified-RAM arbiter (rsa_mem_arbiter) and
// its latency down-counter (rsa_arb_lat_counter).
//   arb_state_t : IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE access sequence
//   arb_owner_t : which requester owns the access in flight
//   LAT_W       : latency counter width, sized for the largest legal MEM_LAT
// -----------------------------------------------------------------------------
package rsa_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    // Legal RAM read latency is 1..MEM_LAT_MAX; the counter only ever holds
    // MEM_LAT-1, so $clog2(MEM_LAT_MAX+1) bits always suffice.
    localparam int MEM_LAT_MAX = 4;
    localparam int LAT_W       = $clog2(MEM_LAT_MAX + 1);

endpackage

// File: rtl/rsa_arb_lat_counter.sv
// -----------------------------------------------------------------------------
// rsa_arb_lat_counter
// Loadable down-counter timing the RAM read latency while the arbiter waits.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (count -> 0)
//   i_load       : load i_load_val (takes precedence over i_dec)
//   i_load_val   : value to load
//   i_dec        : decrement by one, saturating at zero
//   o_zero       : count is zero
//   o_last       : count is one, i.e. this decrement reaches zero
// -----------------------------------------------------------------------------
module rsa_arb_lat_counter
    import rsa_mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero,
    output logic             o_last
);

    logic [LAT_W-1:0] r_cnt;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
    assign o_last = (r_cnt == LAT_W'(1));

endmodule

// File: rtl/rsa_mem_arbiter.sv
// -----------------------------------------------------------------------------
// rsa_mem_arbiter
// Shares one single-port synchronous RAM between the fetch requester (IF) and
// the memory-stage requester (DM). Each access runs IDLE -> ISSUE -> WAIT ->
// RESP; DM has priority because it belongs to the older instruction. stall_o
// freezes the pipeline while any request is outstanding.
// Optional build macro: RSA_ARB_STARVE_GUARD_EN -- after STARVE_MAX
// consecutive DM grants taken while IF was waiting, IF wins the next grant.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   if_req_i/if_addr_i              : fetch request (held until if_valid_o)
//   if_rdata_o/if_valid_o           : fetched word, one-cycle completion pulse
//   dm_req_i/dm_we_i/dm_addr_i/
//   dm_wdata_i                      : data request (held until dm_valid_o)
//   dm_rdata_o/dm_valid_o           : read data, one-cycle completion pulse
//   stall_o                         : pipeline stall
//   mem_en_o/mem_we_o/mem_addr_o/
//   mem_wdata_o/mem_rdata_i         : RAM interface
// -----------------------------------------------------------------------------
module rsa_mem_arbiter
    import rsa_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX || STARVE_MAX < 1) begin : g_bad_param
        $error("rsa_mem_arbiter: MEM_LAT must be 1..4 and STARVE_MAX >= 1");
    end

    arb_state_t        r_state, w_state_next;
    arb_owner_t        r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
    logic              w_grant, w_pick_dm, w_grant_dm;
    logic              w_cnt_load, w_cnt_dec, w_cnt_zero, w_cnt_last;
    logic              w_resp_rd_if, w_resp_rd_dm;

`ifdef RSA_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_starve_hit;

    // IF overrides DM priority only when both are waiting at the limit.
    assign w_starve_hit = if_req_i && (r_starve_cnt == STARVE_W'(STARVE_MAX));
    assign w_pick_dm    = dm_req_i && !w_starve_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            if (!w_grant_dm) begin
                r_starve_cnt <= '0;
            end else if (if_req_i && (r_starve_cnt != STARVE_W'(STARVE_MAX))) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end
`else
    assign w_pick_dm = dm_req_i;
`endif

    assign w_grant_dm = w_grant && w_pick_dm;

    rsa_arb_lat_counter u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (LAT_W'(MEM_LAT - 1)),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero),
        .o_last     (w_cnt_last)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        case (r_state)
            IDLE: begin
                if (if_req_i || dm_req_i) begin
                    w_grant      = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt_load   = 1'b1;
                w_state_next = (MEM_LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
                // Leave on the decrement that takes the count to zero so the
                // response cycle lands exactly MEM_LAT cycles after ISSUE.
                w_cnt_dec = 1'b1;
                if (w_cnt_last || w_cnt_zero) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_owner    <= w_grant_dm ? OWN_DM : OWN_IF;
                r_we       <= w_grant_dm && dm_we_i;
                r_mem_addr <= w_grant_dm ? dm_addr_i : if_addr_i;
                if (w_grant_dm) begin
                    r_mem_wdata <= dm_wdata_i;
                end
            end
            if (w_resp_rd_if) begin
                r_if_rdata <= mem_rdata_i;
            end
            if (w_resp_rd_dm) begin
                r_dm_rdata <= mem_rdata_i;
            end
        end
    end

    // The RAM presents read data during the RESP cycle; it is forwarded to the
    // owner alongside its valid pulse and kept in the hold register afterwards.
    assign w_resp_rd_if = (r_state == RESP) && !r_we && (r_owner == OWN_IF);
    assign w_resp_rd_dm = (r_state == RESP) && !r_we && (r_owner == OWN_DM);

    assign if_rdata_o  = w_resp_rd_if ? mem_rdata_i : r_if_rdata;
    assign dm_rdata_o  = w_resp_rd_dm ? mem_rdata_i : r_dm_rdata;
    assign if_valid_o  = (r_state == RESP) && (r_owner == OWN_IF);
    assign dm_valid_o  = (r_state == RESP) && (r_owner == OWN_DM);
    assign mem_en_o    = (r_state == ISSUE);
    assign mem_we_o    = (r_state == ISSUE) && r_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    // Drops in the valid cycle so the pipeline advances exactly once.
    assign stall_o = (if_req_i && !if_valid_o) || (dm_req_i && !dm_valid_o);

endmodule

// File: tb/tb_rsa_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rsa_mem_arbiter
// Directed bench for rsa_mem_arbiter. Instance 0 runs MEM_LAT=1, instance 1
// runs MEM_LAT=3; both use STARVE_MAX=2 and each drives its own behavioural
// synchronous RAM whose read data appears MEM_LAT cycles after the enable.
// Starvation expectations follow RSA_ARB_STARVE_GUARD_EN.
// -----------------------------------------------------------------------------
module tb_rsa_mem_arbiter;
    import rsa_mem_arb_pkg::*;

    logic        clk;
    logic        init_ram;
    logic        rst       [2];
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic [31:0] if_rdata  [2];
    logic        if_valid  [2];
    logic        dm_req    [2];
    logic        dm_we     [2];
    logic [31:0] dm_addr   [2];
    logic [31:0] dm_wdata  [2];
    logic [31:0] dm_rdata  [2];
    logic        dm_valid  [2];
    logic        stall     [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem  [256];
        logic [31:0] pipe [LAT];

        rsa_mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(2)
        ) u_dut (
            .clk         (clk),
            .reset       (rst[g]),
            .if_req_i    (if_req[g]),
            .if_addr_i   (if_addr[g]),
            .if_rdata_o  (if_rdata[g]),
            .if_valid_o  (if_valid[g]),
            .dm_req_i    (dm_req[g]),
            .dm_we_i     (dm_we[g]),
            .dm_addr_i   (dm_addr[g]),
            .dm_wdata_i  (dm_wdata[g]),
            .dm_rdata_o  (dm_rdata[g]),
            .dm_valid_o  (dm_valid[g]),
            .stall_o     (stall[g]),
            .mem_en_o    (mem_en[g]),
            .mem_we_o    (mem_we[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (mem_rdata[g])
        );

        // RAM model indexed by the low address byte; non-read cycles push a
        // marker so mistimed captures are visible.
        always @(posedge clk) begin
            if (init_ram) begin
                for (int k = 0; k < 256; k++) mem[k] <= 32'hA5A5_A500 | 32'(k);
                mem[8'h00] <= 32'hE3A0_0001;
                mem[8'h04] <= 32'hE3A0_0002;
                mem[8'h08] <= 32'hE3A0_0003;
                mem[8'h10] <= 32'hE3A0_1005;
                mem[8'h14] <= 32'hE3A0_2006;
                mem[8'h40] <= 32'h0000_0000;
            end else if (mem_en[g] && mem_we[g]) begin
                mem[mem_addr[g][7:0]] <= mem_wdata[g];
            end
            pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g][7:0]] : 32'hDEAD_BEEF;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    int en_cnt0 = 0, ifv_cnt0 = 0, en_cnt1 = 0, v_cnt1 = 0;
    always @(negedge clk) begin
        if (mem_en[0])                 en_cnt0++;
        if (if_valid[0])               ifv_cnt0++;
        if (mem_en[1])                 en_cnt1++;
        if (if_valid[1] || dm_valid[1]) v_cnt1++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_fetch [3];
        logic [7:0]  glog [8];
        int          nlog, n_if, n_dm, lat, e0, v0;
        logic        seen;

        exp_fetch[0] = 32'hE3A0_0001;
        exp_fetch[1] = 32'hE3A0_0002;
        exp_fetch[2] = 32'hE3A0_0003;

        init_ram = 1'b1;
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1; if_req[g] = 1'b0; if_addr[g] = '0;
            dm_req[g] = 1'b0; dm_we[g] = 1'b0; dm_addr[g] = '0; dm_wdata[g] = '0;
        end
        repeat (2) cyc();
        init_ram = 1'b0;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("rst%0d_mem_en", g),   mem_en[g],    0);
            check($sformatf("rst%0d_mem_we", g),   mem_we[g],    0);
            check($sformatf("rst%0d_mem_addr", g), mem_addr[g],  0);
            check($sformatf("rst%0d_if_valid", g), if_valid[g],  0);
            check($sformatf("rst%0d_dm_valid", g), dm_valid[g],  0);
            check($sformatf("rst%0d_if_rdata", g), if_rdata[g],  0);
            check($sformatf("rst%0d_stall", g),    stall[g],     0);
        end

        // Single fetch, MEM_LAT=1
        rst[0] = 1'b0; rst[1] = 1'b0;
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        #1;
        check("t1_c0_stall", stall[0], 1);
        check("t1_c0_en", mem_en[0], 0);
        cyc();
        check("t1_c1_en", mem_en[0], 1);
        check("t1_c1_we", mem_we[0], 0);
        check("t1_c1_addr", mem_addr[0], 32'h10);
        check("t1_c1_stall", stall[0], 1);
        check("t1_c1_ifv", if_valid[0], 0);
        cyc();
        check("t1_c2_ifv", if_valid[0], 1);
        check("t1_c2_rdata", if_rdata[0], 32'hE3A0_1005);
        check("t1_c2_stall", stall[0], 0);
        check("t1_c2_en", mem_en[0], 0);
        cyc();
        if_req[0] = 1'b0; #1;
        check("t1_c3_ifv", if_valid[0], 0);
        check("t1_c3_rdata_hold", if_rdata[0], 32'hE3A0_1005);

        // Simultaneous DM write + IF fetch: DM first
        cyc();
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h40; dm_wdata[0] = 32'h0000_CAFE;
        if_req[0] = 1'b1; if_addr[0] = 32'h14;
        cyc();
        check("t2_c1_en", mem_en[0], 1);
        check("t2_c1_we", mem_we[0], 1);
        check("t2_c1_addr", mem_addr[0], 32'h40);
        check("t2_c1_wdata", mem_wdata[0], 32'h0000_CAFE);
        cyc();
        check("t2_c2_dmv", dm_valid[0], 1);
        check("t2_c2_ifv", if_valid[0], 0);
        check("t2_c2_stall", stall[0], 1);
        check("t2_c2_dm_rdata", dm_rdata[0], 0);
        cyc();
        dm_req[0] = 1'b0; dm_we[0] = 1'b0; #1;
        check("t2_c3_en", mem_en[0], 0);
        check("t2_c3_stall", stall[0], 1);
        cyc();
        check("t2_c4_en", mem_en[0], 1);
        check("t2_c4_we", mem_we[0], 0);
        check("t2_c4_addr", mem_addr[0], 32'h14);
        cyc();
        check("t2_c5_ifv", if_valid[0], 1);
        check("t2_c5_rdata", if_rdata[0], 32'hE3A0_2006);
        check("t2_c5_stall", stall[0], 0);
        cyc();
        if_req[0] = 1'b0;
        check("t2_ram40", g_dut[0].mem[8'h40], 32'h0000_CAFE);

        // IF held high across three fetches: no duplicate issue
        cyc();
        e0 = en_cnt0; v0 = ifv_cnt0;
        if_req[0] = 1'b1; if_addr[0] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
                cyc();
                seen = if_valid[0];
            end
            check($sformatf("t5_valid%0d_seen", i), seen, 1);
            check($sformatf("t5_rdata%0d", i), if_rdata[0], exp_fetch[i]);
            cyc();
            if (i < 2) if_addr[0] = 32'(4 * (i + 1));
            else       if_req[0]  = 1'b0;
        end
        repeat (5) cyc();
        check("t5_en_pulses", 32'(en_cnt0 - e0), 3);
        check("t5_ifv_pulses", 32'(ifv_cnt0 - v0), 3);

        // Starvation: DM requesting continuously with new addresses, IF waiting
        rst[0] = 1'b1;
        cyc();
        rst[0] = 1'b0;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h80;
        if_req[0] = 1'b1; if_addr[0] = 32'h0;
        nlog = 0; n_if = 0; n_dm = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (dm_valid[0]) begin
                n_dm++;
                if (nlog < 8) begin glog[nlog] = "D"; nlog++; end
                dm_addr[0] = dm_addr[0] + 32'h4;
            end
            if (if_valid[0]) begin
                n_if++;
                if (nlog < 8) begin glog[nlog] = "I"; nlog++; end
                if_req[0] = 1'b0;
            end
        end
        dm_req[0] = 1'b0; if_req[0] = 1'b0;
`ifdef RSA_ARB_STARVE_GUARD_EN
        check("t6_grant0", 32'(glog[0]), 32'("D"));
        check("t6_grant1", 32'(glog[1]), 32'("D"));
        check("t6_grant2", 32'(glog[2]), 32'("I"));
        check("t6_if_count", 32'(n_if), 1);
        check("t6_dm_count", 32'(n_dm), 6);
`else
        check("t6_if_count", 32'(n_if), 0);
        check("t6_dm_count", 32'(n_dm), 7);
`endif
        cyc();

        // MEM_LAT=3: DM write then read back
        dm_req[1] = 1'b1; dm_we[1] = 1'b1; dm_addr[1] = 32'h40; dm_wdata[1] = 32'h0000_CAFE;
        lat = 0;
        for (int t = 1; t <= 10 && lat == 0; t++) begin
            cyc();
            if (dm_valid[1]) lat = t;
        end
        check("t3_wr_latency", 32'(lat), 4);
        cyc();
        dm_req[1] = 1'b0; dm_we[1] = 1'b0;
        cyc();
        dm_req[1] = 1'b1; dm_addr[1] = 32'h40;
        cyc();
        check("t3_c1_en", mem_en[1], 1);
        check("t3_c1_we", mem_we[1], 0);
        check("t3_c1_addr", mem_addr[1], 32'h40);
        cyc();
        check("t3_c2_en", mem_en[1], 0);
        check("t3_c2_dmv", dm_valid[1], 0);
        cyc();
        check("t3_c3_dmv", dm_valid[1], 0);
        cyc();
        check("t3_c4_dmv", dm_valid[1], 1);
        check("t3_c4_rdata", dm_rdata[1], 32'h0000_CAFE);
        check("t3_c4_stall", stall[1], 0);
        cyc();
        dm_req[1] = 1'b0; #1;
        check("t3_rdata_hold", dm_rdata[1], 32'h0000_CAFE);

        // Reset during WAIT (MEM_LAT=3)
        cyc();
        if_req[1] = 1'b1; if_addr[1] = 32'h10;
        cyc();
        check("t4_c1_en", mem_en[1], 1);
        cyc();
        check("t4_c2_state", 32'(g_dut[1].u_dut.r_state), 32'(WAIT));
        rst[1] = 1'b1; if_req[1] = 1'b0;
        cyc();
        rst[1] = 1'b0; #1;
        check("t4_state", 32'(g_dut[1].u_dut.r_state), 32'(IDLE));
        check("t4_mem_en", mem_en[1], 0);
        check("t4_mem_we", mem_we[1], 0);
        check("t4_mem_addr", mem_addr[1], 0);
        check("t4_mem_wdata", mem_wdata[1], 0);
        check("t4_dm_rdata", dm_rdata[1], 0);
        check("t4_if_rdata", if_rdata[1], 0);
        check("t4_ifv", if_valid[1], 0);
        check("t4_stall", stall[1], 0);
        e0 = en_cnt1; v0 = v_cnt1;
        repeat (5) cyc();
        check("t4_no_valid", 32'(v_cnt1 - v0), 0);
        check("t4_no_issue", 32'(en_cnt1 - e0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
